sie_phase_sequencer: RTL
========================

// Module: sie_phase_sequencer
// PURPOSE
//  Sequences one Schumann Ignition Event (SIE) through coherence, ignition, plateau, propagation and decay.
//  Phase durations come from config_controller; a refractory period follows each event.
//  Sits between config_controller and the oscillator/PAC datapath.
//  Emits the current phase code, a Q14 ignition gain envelope and event bookkeeping.
// PARAMETERS
//  WIDTH      18      signed gain word width
//  FRAC       14      gain fraction bits (Q14; 1.0 = 16384)
//  GAIN_MAX   16384   plateau gain (Q14)
//  GAIN_STEP  8       gain increment/decrement per clk_en tick in ramp phases
// PORTS
//  clk              in   1      system clock (single clock domain)
//  rst              in   1      synchronous, active-high reset
//  clk_en           in   1      4 kHz update strobe; all timing counts in clk_en ticks
//  trigger          in   1      ignition request; sampled only when clk_en=1
//  abort            in   1      force active event into refractory; sampled only when clk_en=1
//  sie_phase2_dur   in   16     coherence duration (ticks)
//  sie_phase3_dur   in   16     ignition duration
//  sie_phase4_dur   in   16     plateau duration
//  sie_phase5_dur   in   16     propagation duration
//  sie_phase6_dur   in   16     decay duration
//  sie_refractory   in   16     refractory duration
//  sie_phase        out  3      0=IDLE, 2..6=event phase, 7=REFRACTORY (1 unused)
//  sie_active       out  1      1 while sie_phase in 2..6
//  phase_start      out  1      one-clk pulse on entry to each of phases 2..7
//  phase_remaining  out  16     ticks left in current phase; 0 in IDLE
//  sie_gain         out  WIDTH  signed Q14 envelope, 0..GAIN_MAX
//  event_count      out  8      accepted triggers, wraps 255->0
//  trigger_dropped  out  1      one-clk pulse when a sampled trigger is not accepted
// BEHAVIOUR
//  - Reset (synchronous): sie_phase=0, phase_remaining=0, sie_gain=0, event_count=0; all pulses 0; snapshots 0.
//    Reset asserted mid-event returns the block to IDLE on that edge, with no refractory.
//  - All outputs are registered. State advances only on cycles with clk_en=1; pulses last exactly one clk.
//  - Trigger acceptance: in IDLE with trigger=1 and abort=0, all six durations are snapshotted.
//    Next edge: sie_phase=2, phase_remaining=max(dur2,1)-1, phase_start=1, event_count+1.
//  - Snapshot rule: later changes on the dur inputs (config state switch) do not affect the event in flight.
//  - Each phase lasts max(dur,1) ticks. A duration of 0 is treated as 1.
//    On a tick with phase_remaining==0, advance 2->3->4->5->6->7->0.
//    Otherwise decrement phase_remaining.
//  - REFRACTORY(7) exit goes to IDLE. A trigger on the same tick as that exit is dropped;
//    re-ignition needs a tick in IDLE.
//  - trigger=1 sampled in any phase other than IDLE, or together with abort in IDLE -> trigger_dropped pulse.
//    State is unchanged.
//  - abort=1 in phases 2..6 -> next tick: phase 7, phase_remaining=max(refr,1)-1, sie_gain=0, phase_start=1.
//    abort in IDLE or REFRACTORY is ignored. abort beats phase-end advance on the same tick.
//  - Gain per tick, saturating arithmetic, no wrap:
//    phase 2: gain 0; phase 3: +GAIN_STEP clamped at GAIN_MAX; phase 4/5: hold GAIN_MAX;
//    phase 6: -GAIN_STEP clamped at 0; phases 7/0: gain 0.
//  - sie_active is combinational from the registered sie_phase (no added latency).
// STRUCTURE
//  - Shared package sie_pkg: phase codes (SIE_IDLE=0, SIE_P2..SIE_P6, SIE_REFR=7) and Q14 ONE constant.
//    config_controller also uses this package.
//  - One sub-module, sie_phase_timer: 16-bit load/decrement counter with a zero flag and min-1 load clamp.
//  - The FSM, snapshot registers and gain envelope live in the top module.
// TESTING
//  - Normal event, durs 3/2/2/4/2 and refr 3, trigger pulse:
//    phase sequence 2x3, 3x2, 4x2, 5x4, 6x2, 7x3, then 0; six phase_start pulses; event_count=1.
//  - GAIN_STEP=8000, dur3=3: gain 8000, 16000, 16384 (clamped);
//    decay dur6=3: 8384, 384, 0; never negative.
//  - Snapshot: change dur5 from 4 to 100 during phase 3 -> phase 5 still lasts 4 ticks.
//  - Abort in phase 4 -> next tick phase 7 with gain 0; trigger during refractory -> trigger_dropped, event_count unchanged.
//  - Zero durations (all 0): each phase lasts 1 tick, full event plus refractory takes 6 ticks.
//    Simultaneous trigger+abort in IDLE -> stays 0, trigger_dropped=1.
//  - rst asserted in phase 5 -> next edge all outputs at reset values.
//    event_count wraps 255->0 on the 256th accepted trigger.

Source files
------------

// File: rtl/sie_pkg.sv
// Shared SIE definitions: phase codes and the Q14 unity constant.
// Also used by config_controller.
package sie_pkg;

   typedef enum logic [2:0] {
      SIE_IDLE = 3'd0,
      SIE_P2   = 3'd2,
      SIE_P3   = 3'd3,
      SIE_P4   = 3'd4,
      SIE_P5   = 3'd5,
      SIE_P6   = 3'd6,
      SIE_REFR = 3'd7
   } sie_phase_e;

   localparam int SIE_Q14_ONE = 16384;

endpackage

// File: rtl/sie_phase_timer.sv
// Phase tick counter: loads max(val,1)-1, decrements on ticks, flags zero.
module sie_phase_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   output logic [15:0] o_count,
   output logic        o_zero
);

   logic [15:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (i_load)
         r_count <= (i_load_val == 16'd0) ? 16'd0 : i_load_val - 16'd1;
      else if (i_tick && r_count != 16'd0)
         r_count <= r_count - 16'd1;
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == 16'd0);

endmodule

// File: rtl/sie_phase_sequencer.sv
// Sequences one Schumann Ignition Event through phases 2..6 plus refractory,
// with snapshotted durations and a saturating Q14 gain envelope.
module sie_phase_sequencer
   import sie_pkg::*;
#(
   parameter int WIDTH     = 18,
   parameter int FRAC      = 14,
   parameter int GAIN_MAX  = (1 << FRAC),
   parameter int GAIN_STEP = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic                    trigger,
   input  logic                    abort,
   input  logic [15:0]             sie_phase2_dur,
   input  logic [15:0]             sie_phase3_dur,
   input  logic [15:0]             sie_phase4_dur,
   input  logic [15:0]             sie_phase5_dur,
   input  logic [15:0]             sie_phase6_dur,
   input  logic [15:0]             sie_refractory,
   output logic [2:0]              sie_phase,
   output logic                    sie_active,
   output logic                    phase_start,
   output logic [15:0]             phase_remaining,
   output logic signed [WIDTH-1:0] sie_gain,
   output logic [7:0]              event_count,
   output logic                    trigger_dropped
);

   localparam logic signed [WIDTH-1:0] W_MAX  = WIDTH'(GAIN_MAX);
   localparam logic signed [WIDTH-1:0] W_STEP = WIDTH'(GAIN_STEP);

   sie_phase_e              r_phase;
   logic [15:0]             r_snap [0:5];
   logic signed [WIDTH-1:0] r_gain;
   logic [7:0]              r_count;
   logic                    r_start;
   logic                    r_drop;

   sie_phase_e              w_next;
   logic                    w_load;
   logic [15:0]             w_load_val;
   logic                    w_accept;
   logic                    w_drop;
   logic                    w_zero;
   logic signed [WIDTH-1:0] w_gain;
   logic [2:0]              w_snap_idx;

   sie_phase_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (clk_en),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_count    (phase_remaining),
      .o_zero     (w_zero)
   );

   // snapshot slot of a phase code: 2..6 -> 0..4, refractory 7 -> 5
   assign w_snap_idx = 3'(w_next) - 3'd2;

   always_comb begin
      w_next     = r_phase;
      w_load     = 1'b0;
      w_load_val = '0;
      w_accept   = 1'b0;
      w_drop     = 1'b0;
      if (clk_en) begin
         case (r_phase)
            SIE_IDLE: begin
               if (trigger && !abort) begin
                  w_accept   = 1'b1;
                  w_next     = SIE_P2;
                  w_load     = 1'b1;
                  w_load_val = sie_phase2_dur;
               end else begin
                  w_drop = trigger;
               end
            end
            SIE_REFR: begin
               w_drop = trigger;
               if (w_zero) w_next = SIE_IDLE;
            end
            default: begin
               w_drop = trigger;
               // abort wins over a phase-end advance on the same tick
               if (abort) begin
                  w_next     = SIE_REFR;
                  w_load     = 1'b1;
                  w_load_val = r_snap[5];
               end else if (w_zero) begin
                  w_next     = (r_phase == SIE_P6) ? SIE_REFR : sie_phase_e'(r_phase + 3'd1);
                  w_load     = 1'b1;
                  w_load_val = r_snap[w_snap_idx];
               end
            end
         endcase
      end
   end

   always_comb begin
      w_gain = '0;
      case (w_next)
         SIE_P3:         w_gain = (r_gain > W_MAX - W_STEP) ? W_MAX : r_gain + W_STEP;
         SIE_P4, SIE_P5: w_gain = W_MAX;
         SIE_P6:         w_gain = (r_gain < W_STEP) ? '0 : r_gain - W_STEP;
         default:        w_gain = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= SIE_IDLE;
         r_gain  <= '0;
         r_count <= '0;
         r_start <= 1'b0;
         r_drop  <= 1'b0;
         for (int i = 0; i < 6; i++) r_snap[i] <= '0;
      end else begin
         r_phase <= w_next;
         r_start <= w_load;
         r_drop  <= w_drop;
         if (clk_en) r_gain <= w_gain;
         if (w_accept) begin
            r_count   <= r_count + 8'd1;
            r_snap[0] <= sie_phase2_dur;
            r_snap[1] <= sie_phase3_dur;
            r_snap[2] <= sie_phase4_dur;
            r_snap[3] <= sie_phase5_dur;
            r_snap[4] <= sie_phase6_dur;
            r_snap[5] <= sie_refractory;
         end
      end
   end

   assign sie_phase       = r_phase;
   assign sie_active      = (r_phase != SIE_IDLE) && (r_phase != SIE_REFR);
   assign phase_start     = r_start;
   assign sie_gain        = r_gain;
   assign event_count     = r_count;
   assign trigger_dropped = r_drop;

endmodule
